// File: rtl/xnor_popcount_accumulator_pkg.sv
// Shared helpers for the binary CNN datapath: popcount, ceil-log2 and the
// accumulator width check used at elaboration.
package bcnn_pkg;

    localparam int unsigned POPCNT_MAX_W = 64;

    function automatic int unsigned clog2_f(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) r++;
        return r;
    endfunction

    function automatic int unsigned popcount_f(input logic [POPCNT_MAX_W-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < POPCNT_MAX_W; i++) c += 32'(v[i]);
        return c;
    endfunction

    // The window sum must fit in SUM_WIDTH bits so the accumulator can never wrap.
    function automatic bit sum_width_ok_f(input int vec_w, input int num_beats, input int sum_w);
        if (vec_w < 1 || vec_w > int'(POPCNT_MAX_W)) return 1'b0;
        if (num_beats < 1 || sum_w < 1 || sum_w > 31) return 1'b0;
        return (longint'(1) << sum_w) > (longint'(vec_w) * longint'(num_beats));
    endfunction

endpackage

// File: rtl/xnor_popcount_accumulator_if.sv
// Beat stream in, window result out; master drives beats, slave is the accumulator.
interface xnor_popcount_accumulator_if #(
    parameter int VEC_WIDTH = 4,
    parameter int SUM_WIDTH = 4
);
    logic                 valid_in;
    logic                 clear_in;
    logic [VEC_WIDTH-1:0] act_in;
    logic [VEC_WIDTH-1:0] wgt_in;
    logic [SUM_WIDTH-1:0] popcount;
    logic                 valid_out;
    logic                 busy;

    modport master (
        output valid_in, clear_in, act_in, wgt_in,
        input  popcount, valid_out, busy
    );

    modport slave (
        input  valid_in, clear_in, act_in, wgt_in,
        output popcount, valid_out, busy
    );
endinterface

// File: rtl/xnor_popcount_accumulator_stage.sv
// Stage 1: XNOR one beat, popcount it and register the count with window tags.
module xnor_popcount_stage
    import bcnn_pkg::*;
#(
    parameter int VEC_WIDTH = 4,
    parameter int BSW_W     = clog2_f(VEC_WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_i,
    input  logic                 first_i,
    input  logic                 last_i,
    input  logic [VEC_WIDTH-1:0] act_i,
    input  logic [VEC_WIDTH-1:0] wgt_i,
    output logic                 valid_o,
    output logic                 first_o,
    output logic                 last_o,
    output logic [BSW_W-1:0]     beat_sum_o
);
    logic [VEC_WIDTH-1:0] xnor_v;
    logic [BSW_W-1:0]     beat_sum_d;
    logic [BSW_W-1:0]     beat_sum_q;
    logic                 valid_q;
    logic                 first_q;
    logic                 last_q;

    // Held in a VEC_WIDTH-wide net so the inversion cannot leak into padding bits.
    assign xnor_v     = ~(act_i ^ wgt_i);
    assign beat_sum_d = BSW_W'(popcount_f(64'(xnor_v)));

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            beat_sum_q <= '0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                first_q    <= first_i;
                last_q     <= last_i;
                beat_sum_q <= beat_sum_d;
            end
        end
    end

    assign valid_o    = valid_q;
    assign first_o    = first_q;
    assign last_o     = last_q;
    assign beat_sum_o = beat_sum_q;
endmodule

// File: rtl/xnor_popcount_accumulator.sv
// Windowed XNOR-popcount dot product: beat counter, window FSM, accumulator
// and the strobed output register feeding threshold_activation.
//
//   state | meaning
//   IDLE  | no partial window; next accepted beat is beat 0
//   ACCUM | beat 0 seen, waiting for the remaining beats of the window
module xnor_popcount_accumulator
    import bcnn_pkg::*;
#(
    parameter int VEC_WIDTH = 4,
    parameter int NUM_BEATS = 3,
    parameter int SUM_WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    xnor_popcount_accumulator_if.slave  bus
);
    localparam int CNT_W = (clog2_f(NUM_BEATS) > 0) ? int'(clog2_f(NUM_BEATS)) : 1;
    localparam int BSW_W = int'(clog2_f(VEC_WIDTH + 1));
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BEATS - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ACCUM = 1'b1;

    if (!sum_width_ok_f(VEC_WIDTH, NUM_BEATS, SUM_WIDTH)) begin : g_bad_params
        $error("xnor_popcount_accumulator: need 2**SUM_WIDTH > VEC_WIDTH*NUM_BEATS and NUM_BEATS >= 1");
    end

    logic [0:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     cnt_base;
    logic                 first_tag;
    logic                 last_tag;

    logic                 s1_valid, s1_first, s1_last;
    logic [BSW_W-1:0]     s1_sum;
    logic                 s1_take;

    logic [SUM_WIDTH-1:0] acc_q, acc_d;
    logic                 done_q, done_d;
    logic [SUM_WIDTH-1:0] popcount_q;
    logic                 valid_out_q;

    // A clear restarts the window in the same cycle, so a coincident beat is beat 0.
    always_comb begin
        cnt_base  = bus.clear_in ? '0 : cnt_q;
        first_tag = (cnt_base == '0);
        last_tag  = (cnt_base == LAST_IDX);
        cnt_d     = cnt_base;
        state_d   = bus.clear_in ? IDLE : state_q;
        if (bus.valid_in) begin
            if (last_tag) begin
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                cnt_d   = cnt_base + CNT_W'(1);
                state_d = ACCUM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    xnor_popcount_stage #(
        .VEC_WIDTH (VEC_WIDTH),
        .BSW_W     (BSW_W)
    ) u_stage (
        .clk        (clk),
        .reset      (reset),
        .valid_i    (bus.valid_in),
        .first_i    (first_tag),
        .last_i     (last_tag),
        .act_i      (bus.act_in),
        .wgt_i      (bus.wgt_in),
        .valid_o    (s1_valid),
        .first_o    (s1_first),
        .last_o     (s1_last),
        .beat_sum_o (s1_sum)
    );

    // A clear drops whatever stage 1 holds so a partial window never completes.
    assign s1_take = s1_valid && !bus.clear_in;

    always_comb begin
        acc_d  = acc_q;
        done_d = 1'b0;
        if (s1_take) begin
            acc_d  = s1_first ? SUM_WIDTH'(s1_sum) : acc_q + SUM_WIDTH'(s1_sum);
            done_d = s1_last;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            done_q      <= 1'b0;
            popcount_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            done_q      <= done_d;
            valid_out_q <= done_q;
            if (done_q) popcount_q <= acc_q;
        end
    end

    assign bus.popcount  = popcount_q;
    assign bus.valid_out = valid_out_q;
    assign bus.busy      = (state_q == ACCUM);
endmodule

// File: tb/tb_xnor_popcount_accumulator.sv
// Randomized scoreboard bench for xnor_popcount_accumulator at default parameters.
module tb_xnor_popcount_accumulator;
    localparam int VW = 4;
    localparam int NB = 3;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    xnor_popcount_accumulator_if #(.VEC_WIDTH(VW), .SUM_WIDTH(SW)) bus ();

    xnor_popcount_accumulator #(
        .VEC_WIDTH (VW),
        .NUM_BEATS (NB),
        .SUM_WIDTH (SW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;
    int exp_val[$];
    int exp_edge[$];
    int m_cnt = 0;
    int m_sum = 0;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (edge %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding window, at its edge.
    always @(negedge clk) begin : monitor
        int v, e;
        if (bus.valid_out === 1'b1) begin
            if (exp_val.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_strobe: got popcount %0d want no strobe (edge %0d)",
                         bus.popcount, cyc);
            end else begin
                v = exp_val.pop_front();
                e = exp_edge.pop_front();
                check("popcount", int'(bus.popcount), v);
                check("strobe_edge", cyc, e);
            end
        end
    end

    task automatic step(input logic v, input logic c, input logic [VW-1:0] a, input logic [VW-1:0] w);
        bus.valid_in = v;
        bus.clear_in = c;
        bus.act_in   = a;
        bus.wgt_in   = w;
        @(posedge clk);
        #1;
        if (c) begin
            // A window whose last beat was on the previous edge is still in flight and dies.
            if (exp_edge.size() > 0 && exp_edge[$] == cyc + 1) begin
                void'(exp_val.pop_back());
                void'(exp_edge.pop_back());
            end
            m_cnt = 0;
            m_sum = 0;
        end
        if (v) begin
            m_sum += $countones(~(a ^ w));
            m_cnt++;
            if (m_cnt == NB) begin
                exp_val.push_back(m_sum);
                exp_edge.push_back(cyc + 2);
                m_cnt = 0;
                m_sum = 0;
            end
        end
        check("busy", int'(bus.busy), (m_cnt != 0) ? 1 : 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, VW'($urandom), VW'($urandom));
    endtask

    task automatic do_reset(input int n);
        int r_edge;
        r_edge = 0;
        reset = 1'b1;
        bus.valid_in = 1'b1;
        bus.clear_in = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.act_in = VW'($urandom);
            bus.wgt_in = VW'($urandom);
            @(posedge clk);
            #1;
            if (i == 0) begin
                r_edge = cyc;
                while (exp_edge.size() > 0 && exp_edge[$] >= r_edge) begin
                    void'(exp_val.pop_back());
                    void'(exp_edge.pop_back());
                end
            end
            check("rst_popcount", int'(bus.popcount), 0);
            check("rst_valid_out", int'(bus.valid_out), 0);
            check("rst_busy", int'(bus.busy), 0);
        end
        m_cnt = 0;
        m_sum = 0;
        reset = 1'b0;
        bus.valid_in = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        bus.valid_in = 1'b0;
        bus.clear_in = 1'b0;
        bus.act_in   = '0;
        bus.wgt_in   = '0;
        do_reset(3);

        // Full match window, then a zero-match window back to back.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'b1010, 4'b1010);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'b1111, 4'b0000);
        idle(4);

        // Gaps of 0, 2 and 5 cycles inside one window.
        step(1'b1, 1'b0, 4'b1100, 4'b1010);
        step(1'b1, 1'b0, 4'b1100, 4'b1010);
        idle(2);
        step(1'b1, 1'b0, 4'b1100, 4'b1010);
        idle(5);

        // Alternating 4/0 matches over two windows with no bubble.
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b0, 4'b1111, (i % 2 == 0) ? 4'b1111 : 4'b0000);
        idle(4);

        // Clear alone aborts a partial window.
        step(1'b1, 1'b0, 4'b1111, 4'b1111);
        step(1'b1, 1'b0, 4'b1111, 4'b1111);
        step(1'b0, 1'b1, 4'b0000, 4'b0000);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'b0001, 4'b1111);
        idle(4);

        // Clear with a coincident beat starts a new window with that beat.
        step(1'b1, 1'b0, 4'b1111, 4'b1111);
        step(1'b1, 1'b1, 4'b1111, 4'b1111);
        step(1'b1, 1'b0, 4'b0001, 4'b1111);
        step(1'b1, 1'b0, 4'b0001, 4'b1111);
        idle(4);

        // Reset mid-window, then a clean window.
        step(1'b1, 1'b0, 4'b1111, 4'b1111);
        step(1'b1, 1'b0, 4'b1111, 4'b1111);
        do_reset(1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'b1100, 4'b1010);
        idle(4);

        // Random traffic with gaps, clears and occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0)
                do_reset(1 + $urandom_range(0, 1));
            else
                step(($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0),
                     VW'($urandom), VW'($urandom));
        end
        idle(6);

        check("outstanding_results", exp_val.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/xnor_popcount_accumulator.md
# xnor_popcount_accumulator

Upstream producer for `threshold_activation`. It streams binary activation and weight words in beats of `VEC_WIDTH` bits and XNORs each beat. It popcounts each beat and accumulates the counts over a window of `NUM_BEATS` beats. At the end of each window it emits one `popcount` with a single-cycle `valid_out`, which connects directly to `threshold_activation.popcount` and `threshold_activation.valid_in`.

## Interface
Parameters:
- `VEC_WIDTH`, default 4: bits per input beat.
- `NUM_BEATS`, default 3: beats per dot-product window; must be ≥ 1.
- `SUM_WIDTH`, default 4: output width. Must satisfy 2^`SUM_WIDTH` > `VEC_WIDTH`*`NUM_BEATS`; elaboration fails otherwise.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `valid_in`  in  1  beat qualifier.
- `clear_in`  in  1  synchronous abort of the partial window.
- `act_in`  in  `VEC_WIDTH`  activation bits; 1 = +1, 0 = −1.
- `wgt_in`  in  `VEC_WIDTH`  weight bits, same encoding.
- `popcount`  out  `SUM_WIDTH`  window sum of XNOR matches.
- `valid_out`  out  1  one-cycle strobe qualifying `popcount`.
- `busy`  out  1  high while a window is partially accumulated.

Reset (`reset` high): `popcount`=0, `valid_out`=0, `busy`=0, beat counter=0, stage-1 valid=0.

## Operation
- Stage 1, registered:
  - `beat_sum` = popcount(~(`act_in` ^ `wgt_in`)), range 0..`VEC_WIDTH`.
  - Tagged with `first` (beat index 0) and `last` (beat index `NUM_BEATS`−1).
  - Valid = `valid_in` && !`clear_in`, or `valid_in` with the `clear_in` rule below.
- Beat counter counts 0..`NUM_BEATS`−1 and advances only on an accepted beat. It wraps to 0 after the last beat.
- FSM:
  - IDLE: counter=0. An accepted beat moves to ACCUM, unless `NUM_BEATS`=1, which stays in IDLE.
  - ACCUM: the last accepted beat returns to IDLE.
  - `busy` = (state==ACCUM).
- Stage 2 accumulator: on a valid stage-1 entry, acc ← `first` ? `beat_sum` : acc + `beat_sum`. Width is `SUM_WIDTH`; it never overflows by construction.
- On a valid stage-1 entry with `last`=1: `popcount` ← final sum and `valid_out` ← 1 for exactly one cycle. Otherwise `valid_out` ← 0.
- `popcount` holds its value between strobes.
- `valid_in` low inside a window is a gap. Counter, FSM and accumulator hold. Gaps of any length are legal.
- Back-to-back windows: the next window's first beat may arrive the cycle after the previous last beat, with no bubble.
- `clear_in` high:
  - Counter → 0, FSM → IDLE.
  - The in-flight stage-1 entry is invalidated, so no partial sum reaches the output.
  - If `valid_in` is also high, that beat is accepted as beat 0 of a new window.
  - A `valid_out` strobe already registered in that cycle still appears.
- `reset` mid-window: all state discarded and no strobe emitted. The first beat after reset is beat 0.
- There is no backpressure. The consumer must accept one result per `valid_out`.

## Timing
- Latency: the final beat is sampled at edge N. `valid_out` is high in the cycle after edge N+2 and low after edge N+3.
- Throughput: one beat per cycle, one result per `NUM_BEATS` cycles at full rate.
- `busy` updates on the edge that samples the beat: high after beat 0 is sampled, low after the last beat is sampled.
- Path through `threshold_activation` adds 1 cycle, so beat-to-activation latency is 3 cycles.

## Structure
- Shared package `bcnn_pkg`:
  - function `popcount_f` (generic-width popcount).
  - function `clog2_f`.
  - the elaboration check for the `SUM_WIDTH` constraint.
- Sub-module `xnor_popcount_stage`:
  - XNOR, popcount and the stage-1 register with first/last tags and valid.
  - Reused later by a parallel multi-lane variant.
- Top level: beat counter, FSM, accumulator, output register.

## Test plan
Defaults `VEC_WIDTH`=4, `NUM_BEATS`=3.
- Reset held 3 cycles with random `act_in` and `valid_in`=1 → `popcount`=0, `valid_out`=0, `busy`=0 throughout. The first beat after release is treated as beat 0.
- Three back-to-back beats, act=1010 and wgt=1010 → `popcount`=12 with `valid_out` high exactly one cycle, 2 edges after the third beat. A second window with act=1111 and wgt=0000 → 0.
- act=1100 and wgt=1010 (XNOR 1001, 2 per beat), beats separated by 0, 2 and 5 idle cycles → single strobe with `popcount`=6. `busy` stays high between beat 0 and beat 2.
- Six consecutive beats alternating 4-match and 0-match (1111/1111, then 1111/0000) → two strobes 3 cycles apart, values 8 then 4. No bubble.
- Two beats of 4 matches, then `clear_in` alone, then three beats of 1 match → only one strobe, value 3. Repeat with `clear_in` and `valid_in` coincident on a 4-match beat, plus two more 1-match beats → strobe value 6.
- `reset` asserted after beat 1 of a 4-match window → no strobe. A following full window of 2-match beats → 6.
